// File: rtl/conv_window_feeder_pkg.sv
// Shared widths, window geometry and FSM encoding for the convolution window feeder.
package conv_window_feeder_pkg;

  localparam int unsigned PIX_W = 9;
  localparam int unsigned KER_W = 2;
  localparam int unsigned K     = 5;
  localparam int unsigned TAPS  = K * K;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StStream = 2'd2,
    StDrain  = 2'd3
  } state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: q_o is the pixel written DEPTH enabled cycles earlier.
module conv_line_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 28
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [PIX_W-1:0] d_i,
  output logic [PIX_W-1:0] q_o
);

  // Storage is deliberately not reset; frame fill flushes stale contents.
  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Streams raster pixels into a 5x5 sliding window backed by four line buffers, and tracks
// window/result timing for a fixed-latency downstream multiply-add tree.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [TAPS*KER_W-1:0]   kernel_in,
  input  logic                    kernel_load,
  output logic [TAPS*PIX_W-1:0]   feature_out,
  output logic [TAPS*KER_W-1:0]   kernel_out,
  output logic                    win_valid,
  output logic                    res_valid,
  output logic                    frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned DrnW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ColW-1:0] LastCol     = ColW'(IMG_W - 1);
  localparam logic [ColW-1:0] FirstWinCol = ColW'(K - 1);
  localparam logic [RowW-1:0] LastRow     = RowW'(IMG_H - 1);
  localparam logic [RowW-1:0] LastFillRow = RowW'(K - 2);
  localparam logic [RowW-1:0] FirstWinRow = RowW'(K - 1);
  localparam logic [DrnW-1:0] LastDrn     = DrnW'(LATENCY - 1);

  state_e                        state_q, state_d;
  logic [RowW-1:0]               row_q, row_d;
  logic [ColW-1:0]               col_q, col_d;
  logic [DrnW-1:0]               drn_q, drn_d;
  logic                          win_valid_q, win_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic [TAPS*KER_W-1:0]         kernel_q;
  logic [TAPS-1:0][PIX_W-1:0]    win_q, win_d;
  logic [LATENCY-1:0]            pipe_q, pipe_d;
  logic                          accept;

  logic [PIX_W-1:0] lb_in  [K-1];
  logic [PIX_W-1:0] lb_out [K-1];
  logic [PIX_W-1:0] col_in [K];

  assign pix_ready = (state_q == StFill) || (state_q == StStream);
  assign accept    = pix_valid && pix_ready;

  // Cascade: buffer j emits the pixel from j+1 rows above the incoming one.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_in[j] = pix_in;
    end else begin : g_tail
      assign lb_in[j] = lb_out[j-1];
    end

    conv_line_buffer #(
      .DEPTH (IMG_W)
    ) u_line_buffer (
      .clk  (clk),
      .en_i (accept),
      .d_i  (lb_in[j]),
      .q_o  (lb_out[j])
    );
  end

  // Newest window column: row K-1 is the live pixel, row 0 the oldest buffered row.
  always_comb begin
    col_in[K-1] = pix_in;
    for (int r = 0; r < int'(K) - 1; r++) begin
      col_in[r] = lb_out[int'(K) - 2 - r];
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          if (c == int'(K) - 1) begin
            win_d[r*int'(K)+c] = col_in[r];
          end else begin
            win_d[r*int'(K)+c] = win_q[r*int'(K)+c+1];
          end
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    drn_d        = drn_q;
    frame_done_d = 1'b0;
    win_valid_d  = accept && (row_q >= FirstWinRow) && (col_q >= FirstWinCol);

    if (accept) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StFill;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StFill: begin
        if (accept && (col_q == LastCol) && (row_q == LastFillRow)) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (accept && (col_q == LastCol) && (row_q == LastRow)) begin
          state_d = StDrain;
          row_d   = '0;
          drn_d   = '0;
        end
      end
      StDrain: begin
        // Leaving here lines frame_done up with the last window's res_valid.
        if (drn_q == LastDrn) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = win_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      drn_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      kernel_q     <= '0;
      win_q        <= '0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      drn_q        <= drn_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      pipe_q       <= pipe_d;
      if (kernel_load && (state_q == StIdle)) begin
        kernel_q <= kernel_in;
      end
    end
  end

  assign feature_out = win_q;
  assign kernel_out  = kernel_q;
  assign win_valid   = win_valid_q;
  assign res_valid   = pipe_q[LATENCY-1];
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomised frame streams against an image-level window model for conv_window_feeder.
module tb_conv_window_feeder;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int LAT  = 6;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 4) * (H - 4);
  localparam logic [49:0] KVAL = 50'h2AAAAAAAAAAAA;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic [8:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [49:0]  kernel_in;
  logic         kernel_load;
  logic [224:0] feature_out;
  logic [49:0]  kernel_out;
  logic         win_valid;
  logic         res_valid;
  logic         frame_done;

  int tests = 0;
  int fails = 0;

  logic [8:0]   img [NPIX];
  int           win_seen = 0;
  int           fd_seen = 0;
  logic [224:0] first_win;
  logic [224:0] last_win;

  conv_window_feeder #(
    .IMG_W   (W),
    .IMG_H   (H),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .kernel_in   (kernel_in),
    .kernel_load (kernel_load),
    .feature_out (feature_out),
    .kernel_out  (kernel_out),
    .win_valid   (win_valid),
    .res_valid   (res_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [224:0] obs, input logic [224:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: a window is due one cycle after accepting pixel (row,col) with row,col >= 4;
  // its contents are the 5x5 image patch ending at that pixel.
  bit prev_acc = 1'b0;
  int prev_idx = 0;
  int acc_count = 0;
  int hist [LAT];

  always @(negedge clk) begin
    int           code;
    int           row;
    int           col;
    logic [224:0] exp_win;
    if (!rst_n) begin
      prev_acc  = 1'b0;
      acc_count = 0;
      for (int i = 0; i < LAT; i++) hist[i] = 0;
    end else begin
      code = 0;
      row  = prev_idx / W;
      col  = prev_idx % W;
      if (prev_acc && row >= 4 && col >= 4) begin
        code = ((row - 4) * (W - 4) + (col - 4) == NWIN - 1) ? 2 : 1;
      end
      chk("win_valid", win_valid, code != 0);
      if (code != 0) begin
        exp_win = '0;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 5; c++) begin
            exp_win[(r*5+c)*9 +: 9] = img[(row - 4 + r) * W + (col - 4 + c)];
          end
        end
        chk("window", feature_out, exp_win);
        if (row == 4 && col == 4) first_win = feature_out;
        if (code == 2) last_win = feature_out;
      end
      chk("res_valid", res_valid, hist[LAT-1] != 0);
      chk("frame_done", frame_done, hist[LAT-1] == 2);
      if (win_valid) win_seen++;
      if (frame_done) fd_seen++;
      for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = code;
      prev_acc = pix_valid && pix_ready;
      if (prev_acc) begin
        prev_idx = acc_count % NPIX;
        acc_count++;
      end
    end
  end

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = 9'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) img[i] = 9'($urandom_range(511));
  endtask

  // Entered and left at posedge+1. stop_after < NPIX leaves the frame unfinished.
  task automatic run_frame(input int duty, input int stop_after, input bit poke);
    int n = 0;
    int cyc = 0;
    int w0 = win_seen;
    int f0 = fd_seen;
    bit poked = 1'b0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (n < stop_after && cyc < 4000) begin
      pix_in    = img[n];
      pix_valid = ($urandom_range(99) < duty);
      if (poke && n == 40 && !poked) begin
        kernel_in   = ~KVAL;
        kernel_load = 1'b1;
        frame_start = 1'b1;
        poked       = 1'b1;
      end
      @(negedge clk);
      if (pix_valid && pix_ready) n++;
      @(posedge clk); #1;
      kernel_load = 1'b0;
      frame_start = 1'b0;
      cyc++;
    end
    pix_valid = 1'b0;
    chk("pixels_accepted", n, stop_after);
    if (stop_after == NPIX) begin
      for (int i = 0; i < 40 && fd_seen == f0; i++) @(posedge clk);
      #1;
      chk("frame_done_count", fd_seen - f0, 1);
      chk("win_count", win_seen - w0, NWIN);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_feature_out", feature_out, '0);
    chk("rst_kernel_out", kernel_out, '0);
  endtask

  initial begin
    rst_n       = 1'b1;
    frame_start = 1'b0;
    pix_in      = '0;
    pix_valid   = 1'b0;
    kernel_in   = '0;
    kernel_load = 1'b0;
    for (int i = 0; i < LAT; i++) hist[i] = 0;
    fill_ramp();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle must refuse pixels.
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_pix_ready", pix_ready, 1'b0);
    pix_valid = 1'b0;

    kernel_in   = KVAL;
    kernel_load = 1'b1;
    @(posedge clk); #1;
    kernel_load = 1'b0;
    chk("kernel_load_idle", kernel_out, KVAL);

    // Ramp image, no stalls.
    first_win = '0;
    last_win  = '0;
    run_frame(100, NPIX, 1'b0);
    chk("first_tap0", first_win[8:0], 9'd0);
    chk("first_tap24", first_win[224:216], 9'd36);
    chk("last_tap24", last_win[224:216], 9'd63);

    // Same image with 50% valid duty.
    run_frame(50, NPIX, 1'b0);

    // Random image; kernel_load and frame_start poked mid-STREAM.
    fill_rand();
    run_frame(50, NPIX, 1'b1);
    chk("kernel_hold_stream", kernel_out, KVAL);

    // Abort after 20 accepted pixels.
    fill_rand();
    run_frame(70, 20, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1 chk("post_abort_ready", pix_ready, 1'b0);

    fill_rand();
    run_frame(60, NPIX, 1'b0);
    fill_rand();
    run_frame(100, NPIX, 1'b0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning pixels per row (at least 5).
REQ-002 SHALL have parameter IMG_H, default 28, meaning rows per frame (at least 5).
REQ-003 SHALL have parameter LATENCY, default 6, meaning downstream multiply-add tree latency in cycles (at least 1).
REQ-004 clk  input  1  rising-edge clock; the block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  single-cycle pulse that opens a frame.
REQ-007 pix_in  input  9  signed pixel, raster order.
REQ-008 pix_valid  input  1  pix_in valid.
REQ-009 pix_ready  output  1  block accepts a pixel this cycle.
REQ-010 kernel_in  input  50  25 signed 2-bit ternary weights.
REQ-011 kernel_load  input  1  capture kernel_in.
REQ-012 feature_out  output  225  5x5 window, 9 bits per tap.
REQ-013 kernel_out  output  50  registered kernel.
REQ-014 win_valid  output  1  feature_out holds a new complete window.
REQ-015 res_valid  output  1  downstream result for a window is ready.
REQ-016 frame_done  output  1  single-cycle pulse at end of frame.

Function
REQ-017 A pixel SHALL be accepted when pix_valid and pix_ready are both high in the same cycle; no other cycle advances the counters.
REQ-018 The FSM SHALL have four states: IDLE (pix_ready=0), FILL (rows 0-3, pix_ready=1), STREAM (rows 4..IMG_H-1, pix_ready=1) and DRAIN (pix_ready=0).
REQ-019 The FSM SHALL make these transitions: IDLE->FILL on frame_start; FILL->STREAM after the last pixel of row 3 is accepted; STREAM->DRAIN after the last pixel of row IMG_H-1 is accepted; DRAIN->IDLE after LATENCY cycles.
REQ-020 frame_start outside IDLE SHALL be ignored.
REQ-021 kernel_load SHALL capture kernel_in into kernel_out on the next edge only in IDLE; it SHALL be ignored in any other state.
REQ-022 Four line buffers of IMG_W x 9 bits plus a 5x5 shift window SHALL hold the last five rows; col wraps IMG_W-1->0 and increments row.
REQ-023 Tap index i=r*5+c SHALL occupy feature_out[i*9+8:i*9], where r=0 is the oldest row, c=0 is the oldest column, and tap 24 is the pixel just accepted.
REQ-024 win_valid SHALL pulse for exactly one cycle, one cycle after acceptance of a pixel with row>=4 and col>=4; feature_out SHALL be stable until the next accepted pixel.
REQ-025 Windows SHALL never straddle a row boundary: acceptances at col<4 SHALL produce no win_valid.
REQ-026 Each frame SHALL produce exactly (IMG_W-4)*(IMG_H-4) win_valid pulses.
REQ-027 res_valid SHALL equal win_valid delayed by exactly LATENCY cycles, using a LATENCY-deep shift register that is not cleared by frame boundaries.
REQ-028 frame_done SHALL pulse in the cycle DRAIN->IDLE occurs, which is the same cycle as the last res_valid of the frame.
REQ-029 Pixel values SHALL pass unmodified: no arithmetic, saturation or sign change.
REQ-030 Line-buffer contents SHALL NOT be cleared between frames; FILL guarantees stale data never reaches a valid window.

Reset
REQ-031 On rst_n low the FSM SHALL go to IDLE and row/col SHALL be 0.
REQ-032 On rst_n low, pix_ready, win_valid, res_valid, frame_done, the delay pipe, feature_out and kernel_out SHALL be 0.
REQ-033 Reset mid-frame SHALL abort the frame immediately; no res_valid SHALL appear after release until a new frame produces windows.
REQ-034 Line-buffer storage SHALL NOT require reset.

Structure
REQ-035 A shared package SHALL hold PIX_W=9, KER_W=2, K=5, TAPS=25 and the FSM state encoding.
REQ-036 One sub-module SHALL be used: conv_line_buffer (single IMG_W x 9 delay line with an enable input), instantiated four times.

Verification (IMG_W=8, IMG_H=8, LATENCY=6)
REQ-037 Frame with pixel value = row*8+col, pix_valid always high -> 16 win_valid pulses; first window tap0=0, tap24=36; last window tap24=63.
REQ-038 Random pix_valid gaps at 50% duty -> same 16 windows with identical contents; no win_valid during stalls.
REQ-039 Each win_valid -> res_valid exactly 6 cycles later; frame_done coincides with the 16th res_valid.
REQ-040 kernel_load with 0x2AAAAAAAAAAAA in IDLE -> kernel_out updated; a later kernel_load in STREAM -> kernel_out unchanged.
REQ-041 rst_n low after 20 accepted pixels -> all outputs 0 and state IDLE; next full frame -> correct 16 windows.
REQ-042 frame_start pulsed during STREAM -> no effect; the frame completes normally.
